muldiv_unit: RTL and testbench

Iterative multiply/divide unit for the execute stage, generalising the single-cycle ALU to parametrised-width, multi-cycle MULT/MULTU/DIV/DIVU with MIPS-style HI/LO result registers. It accepts one operation at a time through a start/busy/done handshake, runs one radix-2 step per clock, and holds the result in HI/LO until overwritten. The pipeline stalls on `busy` and reads results through `hi`/`lo` (MFHI/MFLO) or writes them directly (MTHI/MTLO).

---
 rtl/muldiv_unit.sv | 133 +++++++++++++
 tb/tb_muldiv_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with MIPS-style HI/LO result registers.
// One shift-add or restoring-divide step per clock; result committed on entry to DONE.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state_q;
  logic [CW-1:0]      cnt_q;
  logic [1:0]         op_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [WIDTH-1:0]   a_q;
  logic               neg_q;
  logic               neg_rem_q;
  logic               dz_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic               sa, sb;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] mul_next, div_next;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;
  logic               opnd_zero;

  always_comb begin
    sa    = op[0] & a[WIDTH-1];
    sb    = op[0] & b[WIDTH-1];
    mag_a = sa ? -a : a;
    mag_b = sb ? -b : b;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifting right.
    sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    mul_next = acc_q[0] ? {sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};

    // Divide: acc = {partial remainder, remaining dividend bits}, shifting left.
    trial    = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
    div_next = trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                            : {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    prod      = neg_q ? -acc_q : acc_q;
    quo       = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem       = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    opnd_zero = (opnd_q == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      a_q       <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      if (state_q != RUN) begin
        if (hi_we) hi_q <= wdata;
        if (lo_we) lo_q <= wdata;
      end
      case (state_q)
        RUN: begin
          if (cnt_q == CW'(WIDTH)) begin
            state_q <= DONE;
            if (!op_q[1]) begin
              hi_q <= prod[2*WIDTH-1:WIDTH];
              lo_q <= prod[WIDTH-1:0];
            end else if (opnd_zero) begin
              hi_q <= a_q;
              lo_q <= '1;
              dz_q <= 1'b1;
            end else begin
              hi_q <= rem;
              lo_q <= quo;
            end
          end else begin
            acc_q <= op_q[1] ? div_next : mul_next;
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          if (start) begin
            state_q   <= RUN;
            op_q      <= op;
            acc_q     <= {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
            opnd_q    <= op[1] ? mag_b : mag_a;
            a_q       <= a;
            neg_q     <= sa ^ sb;
            neg_rem_q <= sa;
            cnt_q     <= '0;
            dz_q      <= 1'b0;
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign div_by_zero = dz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed results, latency, handshake and reset cases.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy, done, dz;
  logic [31:0] hi, lo;

  logic        start8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, wdata8;
  logic        busy8, done8, dz8;
  logic [7:0]  hi8, lo8;

  int checks = 0;
  int errors = 0;
  int hs_err = 0;
  int lat;
  int cnt;
  logic [31:0] lo_snap;

  muldiv_unit #(.WIDTH(32)) u_dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
    .div_by_zero(dz), .hi(hi), .lo(lo)
  );

  muldiv_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .hi_we(1'b0), .lo_we(1'b0), .wdata(wdata8), .busy(busy8), .done(done8),
    .div_by_zero(dz8), .hi(hi8), .lo(lo8)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present an op so it is accepted at the next edge (E0); returns #1 after E0.
  task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 32'h5A5A_5A5A; b = 32'hA5A5_A5A5;
  endtask

  // Counts edges after E0 until done; optionally injects a start or MTLO before edge inj.
  task automatic wait_done(input int inj, input logic inj_start, input logic inj_lo,
                           output int latency);
    latency = 0;
    for (int n = 1; n <= 60; n++) begin
      if (n == inj) begin
        if (inj_start) begin start = 1'b1; op = 2'b00; a = 32'd7; b = 32'd7; end
        if (inj_lo) begin lo_we = 1'b1; wdata = 32'h1234; end
      end
      @(posedge clk); #1;
      start = 1'b0; lo_we = 1'b0;
      if (n == inj) lo_snap = lo;
      if (busy && done) hs_err++;
      if (done) begin latency = n; break; end
      if (!busy) hs_err++;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; op = 2'b00;
    a = '0; b = '0; wdata = '0;
    start8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0; wdata8 = '0;
    lo_snap = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dz", dz, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);

    start_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(0, 1'b0, 1'b0, lat);
    chk("multu_lat", lat, 33);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);
    chk("multu_dz", dz, 0);
    @(posedge clk); #1;
    chk("done_pulse", done, 0);

    start_op(2'b01, 32'hFFFF_FFFD, 32'd7);
    wait_done(0, 1'b0, 1'b0, lat);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFEB);

    start_op(2'b11, 32'hFFFF_FFF9, 32'd2);
    wait_done(0, 1'b0, 1'b0, lat);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    start_op(2'b10, 32'd10, 32'd0);
    wait_done(0, 1'b0, 1'b0, lat);
    chk("dz_lat", lat, 33);
    chk("dz_hi", hi, 32'h0000_000A);
    chk("dz_lo", lo, 32'hFFFF_FFFF);
    chk("dz_flag", dz, 1);
    @(posedge clk); #1;
    chk("dz_held", dz, 1);

    start_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("dz_clear", dz, 0);
    wait_done(0, 1'b0, 1'b0, lat);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'h0000_0000);
    chk("ovf_dz", dz, 0);

    start_op(2'b00, 32'd5, 32'd6);
    wait_done(5, 1'b1, 1'b0, lat);
    chk("ign_start_lat", lat, 33);
    chk("ign_start_lo", lo, 32'h1E);
    chk("ign_start_hi", hi, 32'h0);
    @(posedge clk); #1;
    chk("ign_start_idle", busy, 0);

    start_op(2'b10, 32'd100, 32'd7);
    wait_done(5, 1'b0, 1'b1, lat);
    chk("mtlo_run_ignored", lo_snap, 32'h1E);
    chk("mtlo_lat", lat, 33);
    chk("mtlo_lo", lo, 32'h0000_000E);
    chk("mtlo_hi", hi, 32'h0000_0002);

    start_op(2'b00, 32'd3, 32'd4);
    wait_done(0, 1'b0, 1'b0, lat);
    chk("b2b_first_lo", lo, 32'h0C);
    start_op(2'b10, 32'd20, 32'd3);
    chk("b2b_busy", busy, 1);
    chk("b2b_done", done, 0);
    wait_done(0, 1'b0, 1'b0, lat);
    chk("b2b_lat", lat, 33);
    chk("b2b_lo", lo, 32'd6);
    chk("b2b_hi", hi, 32'd2);
    @(posedge clk); #1;

    hi_we = 1'b1; wdata = 32'h0000_ABCD;
    @(posedge clk); #1;
    hi_we = 1'b0;
    chk("mthi_hi", hi, 32'h0000_ABCD);
    chk("mthi_lo", lo, 32'd6);

    start_op(2'b00, 32'hFFFF_FFFF, 32'd2);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_hi", hi, 0);
    chk("rst_mid_lo", lo, 0);
    cnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (done) cnt++;
    end
    chk("rst_no_done", cnt, 0);

    start = 1'b1; reset = 1'b1; op = 2'b00; a = 32'd1; b = 32'd1;
    @(posedge clk); #1;
    start = 1'b0; reset = 1'b0;
    chk("rst_wins", busy, 0);

    op8 = 2'b01; a8 = 8'h80; b8 = 8'h80; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'h11; b8 = 8'h22;
    lat = 0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      if (done8) begin lat = n; break; end
    end
    chk("w8_lat", lat, 9);
    chk("w8_hi", hi8, 8'h40);
    chk("w8_lo", lo8, 8'h00);

    chk("handshake", hs_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
